trace_capture_buffer: RTL and testbench

// - Parametrised on-chip trace unit for the OoO CPU. Samples the fetch and decode

---
 rtl/trace_capture_buffer.sv | 159 +++++++++++++++
 tb/tb_trace_capture_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer
// On-chip trace unit: while running, samples the fetch/decode signals once per
// cycle into a circular buffer, stamping each entry with a cycle count. The
// oldest entry is presented first-word-fall-through on a valid/ready read port.
// Optional feature macro: TRACE_FILTER_NOP_EN. When it is defined, NOP
// instructions (addi x0,x0,0 and the all-zero word) are not captured, but the
// cycle stamp still advances.

module trace_capture_buffer #(
    parameter int DEPTH     = 16,
    parameter int PC_W      = 12,
    parameter int INSTR_W   = 32,
    parameter int CSIG_W    = 7,
    parameter int ALU_W     = 3,
    parameter int CYC_W     = 32,
    parameter int MAX_CAP   = 20,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [PC_W-1:0]          fetch_pc,
    input  logic [INSTR_W-1:0]       fetch_instr,
    input  logic [CSIG_W-1:0]        c_sig,
    input  logic [ALU_W-1:0]         alu_sig,
    input  logic [INSTR_W-1:0]       imm,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [CYC_W-1:0]         rd_cycle,
    output logic [PC_W-1:0]          rd_pc,
    output logic [INSTR_W-1:0]       rd_instr,
    output logic [CSIG_W-1:0]        rd_csig,
    output logic [ALU_W-1:0]         rd_alu,
    output logic [INSTR_W-1:0]       rd_imm,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [CYC_W-1:0]   cyc;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [CSIG_W-1:0]  csig;
        logic [ALU_W-1:0]   alu;
        logic [INSTR_W-1:0] imm;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic [CYC_W-1:0] cyc_cnt, cap_cnt;
    logic            ovf_q;

    logic sample_nop;
    logic running;
    logic capture;
    logic pop;
    logic full;
    logic wr_en;
    logic full_hit;
    logic ovw_adv;
    logic hit_max;

`ifdef TRACE_FILTER_NOP_EN
    assign sample_nop = (fetch_instr == INSTR_W'(32'h0000_0013)) || (fetch_instr == '0);
`else
    assign sample_nop = 1'b0;
`endif

    // A restart takes priority over capturing and popping in the same cycle.
    assign running  = (state_q == ST_RUN);
    assign capture  = running && !start && !sample_nop;
    assign pop      = rd_valid && rd_ready && !start;
    assign full     = (count_q == CW'(DEPTH));
    assign full_hit = capture && full && !pop;
    assign ovw_adv  = full_hit && (OVERWRITE != 0);
    assign wr_en    = capture && (!full_hit || (OVERWRITE != 0));
    assign hit_max  = capture && (MAX_CAP != 0) &&
                      ((cap_cnt + CYC_W'(1)) == CYC_W'(MAX_CAP));

    // Control state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: start always (re)enters RUN; stop or the capture limit ends a run.
    // NOTE: state_d gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (start)                              state_d = ST_RUN;
        else if (running && (stop || hit_max))  state_d = ST_DONE;
    end

    // Pointers, occupancy, sticky overflow, cycle stamp and capture counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            cyc_cnt <= '0;
            cap_cnt <= '0;
        end else if (start) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            cyc_cnt <= '0;
            cap_cnt <= '0;
        end else begin
            if (wr_en)           wr_ptr <= wr_ptr + AW'(1);
            if (pop || ovw_adv)  rd_ptr <= rd_ptr + AW'(1);
            if (pop && !wr_en)
                count_q <= count_q - CW'(1);
            else if (wr_en && !pop && !ovw_adv)
                count_q <= count_q + CW'(1);
            if (full_hit) ovf_q   <= 1'b1;
            if (running)  cyc_cnt <= cyc_cnt + CYC_W'(1);
            if (capture)  cap_cnt <= cap_cnt + CYC_W'(1);
        end
    end

    // Trace storage write port; the entry is stamped with this cycle's count.
    // NOTE: the storage array has no reset; count/pointers gate what is visible, so stale data never leaks.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= '{cyc: cyc_cnt, pc: fetch_pc, instr: fetch_instr,
                                    csig: c_sig, alu: alu_sig, imm: imm};
    end

    assign head     = mem[rd_ptr];
    assign rd_valid = (count_q != '0);
    assign rd_cycle = head.cyc;
    assign rd_pc    = head.pc;
    assign rd_instr = head.instr;
    assign rd_csig  = head.csig;
    assign rd_alu   = head.alu;
    assign rd_imm   = head.imm;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb_trace_capture_buffer
// Drives two trace_capture_buffer instances (drop-when-full and overwrite-oldest)
// with shared directed stimulus and compares both against a queue-based model
// every cycle, plus hand-computed expectations for each scenario.

module tb_trace_capture_buffer;

    localparam int DEPTH   = 16;
    localparam int PC_W    = 12;
    localparam int INSTR_W = 32;
    localparam int CSIG_W  = 7;
    localparam int ALU_W   = 3;
    localparam int CYC_W   = 32;
    localparam int MAX_CAP = 20;
    localparam int CW      = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [CYC_W-1:0]   cyc;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [CSIG_W-1:0]  csig;
        logic [ALU_W-1:0]   alu;
        logic [INSTR_W-1:0] imm;
    } entry_t;

    logic tb_clk = 1'b0;
    logic rst_n, start, stop, rd_ready;
    logic [PC_W-1:0]    fetch_pc;
    logic [INSTR_W-1:0] fetch_instr, imm;
    logic [CSIG_W-1:0]  c_sig;
    logic [ALU_W-1:0]   alu_sig;

    logic               rd_valid_0, rd_valid_1;
    logic [CYC_W-1:0]   rd_cycle_0, rd_cycle_1;
    logic [PC_W-1:0]    rd_pc_0, rd_pc_1;
    logic [INSTR_W-1:0] rd_instr_0, rd_instr_1, rd_imm_0, rd_imm_1;
    logic [CSIG_W-1:0]  rd_csig_0, rd_csig_1;
    logic [ALU_W-1:0]   rd_alu_0, rd_alu_1;
    logic [CW-1:0]      count_0, count_1;
    logic               overflow_0, overflow_1, busy_0, busy_1, done_0, done_1;

    int vectors = 0;
    int errors  = 0;
    bit cmp_en  = 0;

    always #5 tb_clk = ~tb_clk;

    trace_capture_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .CSIG_W(CSIG_W),
        .ALU_W(ALU_W), .CYC_W(CYC_W), .MAX_CAP(MAX_CAP), .OVERWRITE(0)) dut_drop (
        .clk(tb_clk), .rst_n(rst_n), .start(start), .stop(stop),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .c_sig(c_sig), .alu_sig(alu_sig), .imm(imm),
        .rd_valid(rd_valid_0), .rd_ready(rd_ready), .rd_cycle(rd_cycle_0), .rd_pc(rd_pc_0),
        .rd_instr(rd_instr_0), .rd_csig(rd_csig_0), .rd_alu(rd_alu_0), .rd_imm(rd_imm_0),
        .count(count_0), .overflow(overflow_0), .busy(busy_0), .done(done_0));

    trace_capture_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .CSIG_W(CSIG_W),
        .ALU_W(ALU_W), .CYC_W(CYC_W), .MAX_CAP(MAX_CAP), .OVERWRITE(1)) dut_ovw (
        .clk(tb_clk), .rst_n(rst_n), .start(start), .stop(stop),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .c_sig(c_sig), .alu_sig(alu_sig), .imm(imm),
        .rd_valid(rd_valid_1), .rd_ready(rd_ready), .rd_cycle(rd_cycle_1), .rd_pc(rd_pc_1),
        .rd_instr(rd_instr_1), .rd_csig(rd_csig_1), .rd_alu(rd_alu_1), .rd_imm(rd_imm_1),
        .count(count_1), .overflow(overflow_1), .busy(busy_1), .done(done_1));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (index 0 = drop, 1 = overwrite) ----------------
    entry_t           mq [2][$];
    logic [CYC_W-1:0] m_cyc  [2];
    int               m_caps [2];
    bit               m_run  [2];
    bit               m_done [2];
    bit               m_ovf  [2];

    function automatic void model_reset(input int k);
        mq[k].delete();
        m_cyc[k]  = '0;
        m_caps[k] = 0;
        m_run[k]  = 0;
        m_done[k] = 0;
        m_ovf[k]  = 0;
    endfunction

    task automatic model_step(input int k);
        entry_t e;
        bit     nop;
        if (start) begin
            model_reset(k);
            m_run[k] = 1;
            return;
        end
        if (mq[k].size() != 0 && rd_ready) void'(mq[k].pop_front());
        if (m_run[k]) begin
            e   = {m_cyc[k], fetch_pc, fetch_instr, c_sig, alu_sig, imm};
            nop = 0;
`ifdef TRACE_FILTER_NOP_EN
            nop = (fetch_instr == 32'h0000_0013) || (fetch_instr == 32'h0);
`endif
            if (!nop) begin
                m_caps[k]++;
                if (mq[k].size() < DEPTH) mq[k].push_back(e);
                else begin
                    m_ovf[k] = 1;
                    if (k == 1) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(e);
                    end
                end
            end
            m_cyc[k]++;
            if (stop || (MAX_CAP != 0 && m_caps[k] == MAX_CAP)) begin
                m_run[k]  = 0;
                m_done[k] = 1;
            end
        end
    endtask

    always @(posedge tb_clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            else        model_step(k);
        end
    end

    task automatic compare_one(input int k, input logic v, input logic [CW-1:0] cnt,
                               input logic ovf, input logic bsy, input logic dn, input entry_t hd);
        string p;
        p = $sformatf("dut%0d.", k);
        check({p, "rd_valid"}, v, mq[k].size() != 0);
        check({p, "count"}, cnt, mq[k].size());
        check({p, "overflow"}, ovf, m_ovf[k]);
        check({p, "busy"}, bsy, m_run[k]);
        check({p, "done"}, dn, m_done[k]);
        if (mq[k].size() != 0) check({p, "head"}, hd, mq[k][0]);
    endtask

    always @(negedge tb_clk) begin
        if (cmp_en && rst_n) begin
            compare_one(0, rd_valid_0, count_0, overflow_0, busy_0, done_0,
                        {rd_cycle_0, rd_pc_0, rd_instr_0, rd_csig_0, rd_alu_0, rd_imm_0});
            compare_one(1, rd_valid_1, count_1, overflow_1, busy_1, done_1,
                        {rd_cycle_1, rd_pc_1, rd_instr_1, rd_csig_1, rd_alu_1, rd_imm_1});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] instr, input logic stp, input logic rdy);
        fetch_instr = instr;
        stop        = stp;
        rd_ready    = rdy;
        fetch_pc    = PC_W'($urandom);
        c_sig       = CSIG_W'($urandom);
        alu_sig     = ALU_W'($urandom);
        imm         = $urandom;
        @(posedge tb_clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        drive(32'h0000_DEAD, 1'b0, 1'b0);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rd_valid"}, {rd_valid_1, rd_valid_0}, 2'b00);
        check({tag, ".count"}, {count_1, count_0}, '0);
        check({tag, ".overflow"}, {overflow_1, overflow_0}, 2'b00);
        check({tag, ".busy"}, {busy_1, busy_0}, 2'b00);
        check({tag, ".done"}, {done_1, done_0}, 2'b00);
    endtask

    initial begin
        int pops;
        logic [CYC_W-1:0] last0, last1;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; rd_ready = 1'b0;
        fetch_pc = '0; fetch_instr = '0; c_sig = '0; alu_sig = '0; imm = '0;
        drive(32'h0, 1'b0, 1'b0);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        check_reset_outputs("idle");
        cmp_en = 1;

        // A: five captures, no reads, then drain in DONE.
        pulse_start();
        for (int i = 0; i < 5; i++) drive(32'hA0 + i, i == 4, 1'b0);
        check("A.count0", count_0, 5);
        check("A.count1", count_1, 5);
        check("A.done0", done_0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("A.stamp", rd_cycle_0, i);
            check("A.instr", rd_instr_0, 32'hA0 + i);
            drive(32'h0, 1'b0, 1'b1);
        end
        check("A.empty", rd_valid_0, 1'b0);

        // B: auto-stop at MAX_CAP with a consumer always ready.
        pulse_start();
        pops = 0;
        for (int i = 0; i < 25; i++) begin
            if (rd_valid_0) begin
                check("B.stamp", rd_cycle_0, pops);
                pops++;
            end
            drive(32'h100 + i, 1'b0, 1'b1);
            if (i == 18) check("B.done_before", done_0, 1'b0);
            if (i == 19) check("B.done_at20", {done_1, done_0}, 2'b11);
        end
        check("B.pops", pops, 20);
        check("B.count", count_0, 0);

        // C: 18 captures into a 16-deep buffer with no reads.
        pulse_start();
        for (int i = 0; i < 18; i++) drive(32'h200 + i, i == 17, 1'b0);
        check("C.count0", count_0, 16);
        check("C.count1", count_1, 16);
        check("C.ovf", {overflow_1, overflow_0}, 2'b11);
        check("C.head0", rd_cycle_0, 0);
        check("C.head1", rd_cycle_1, 2);
        last0 = '0; last1 = '0;
        for (int i = 0; i < 16; i++) begin
            last0 = rd_cycle_0;
            last1 = rd_cycle_1;
            drive(32'h0, 1'b0, 1'b1);
        end
        check("C.last0", last0, 15);
        check("C.last1", last1, 17);
        check("C.ovf_sticky", {overflow_1, overflow_0}, 2'b11);

        // D: full buffer with a simultaneous pop, then reset mid-run.
        pulse_start();
        for (int i = 0; i < 16; i++) drive(32'h300 + i, 1'b0, 1'b0);
        check("D.full", count_0, 16);
        check("D.ovf_clear", {overflow_1, overflow_0}, 2'b00);
        drive(32'h310, 1'b0, 1'b1);
        check("D.count_pop", {count_1, count_0}, {CW'(16), CW'(16)});
        check("D.ovf_pop", {overflow_1, overflow_0}, 2'b00);
        check("D.busy", busy_0, 1'b1);
        drive(32'h311, 1'b0, 1'b0);
        check("D.ovf_drop", {overflow_1, overflow_0}, 2'b11);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge tb_clk);
        #2;
        rst_n = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        check_reset_outputs("postrst");

        // E: NOP filter behaviour.
        pulse_start();
        drive(32'h13, 1'b0, 1'b0);
        drive(32'hB1, 1'b0, 1'b0);
        drive(32'h0,  1'b0, 1'b0);
        drive(32'hB2, 1'b1, 1'b0);
`ifdef TRACE_FILTER_NOP_EN
        check("E.count", count_0, 2);
        check("E.stamp0", rd_cycle_0, 1);
        check("E.instr0", rd_instr_0, 32'hB1);
        drive(32'h0, 1'b0, 1'b1);
        check("E.stamp1", rd_cycle_0, 3);
        check("E.instr1", rd_instr_0, 32'hB2);
        drive(32'h0, 1'b0, 1'b1);
`else
        check("E.count", count_0, 4);
        for (int i = 0; i < 4; i++) begin
            check("E.stamp", rd_cycle_0, i);
            drive(32'h0, 1'b0, 1'b1);
        end
`endif
        check("E.empty", rd_valid_0, 1'b0);
        drive(32'h0, 1'b0, 1'b0);
        cmp_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
